// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative (radix-2) multiply/divide unit owning HI/LO; stalls dependent HI/LO instructions.
// Build option MULDIV_EARLY_TERM_EN: multiplies leave RUN as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | nothing in flight; HI/LO instructions proceed without stall
// RUN   | one shift-add (mul) or restoring shift-subtract (div) step per cycle
// FIX   | sign correction and HI/LO write-back
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [5:0]      op_in,
    input  logic [5:0]      funct_in,
    input  logic [XLEN-1:0] valA_in,
    input  logic [XLEN-1:0] valB_in,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam logic [5:0] LP_LAST = 6'(XLEN - 1);

    state_t            r_state, w_state_nxt;
    logic [5:0]        r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_hi, r_lo;
    logic              r_is_mul, r_neg_q, r_neg_r, r_dbz;

    logic              w_rtype, w_mult, w_multu, w_div, w_divu;
    logic              w_mfhi, w_mthi, w_mflo, w_mtlo;
    logic              w_is_mul, w_is_div, w_is_signed, w_hilo_use;
    logic              w_busy, w_accept, w_start, w_b_zero, w_mul_done;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic [XLEN:0]     w_trial, w_diff;
    logic [2*XLEN-1:0] w_prod_fix;

    assign w_rtype = (op_in == 6'h00);
    assign w_mult  = w_rtype && (funct_in == 6'h18);
    assign w_multu = w_rtype && (funct_in == 6'h19);
    assign w_div   = w_rtype && (funct_in == 6'h1A);
    assign w_divu  = w_rtype && (funct_in == 6'h1B);
    assign w_mfhi  = w_rtype && (funct_in == 6'h10);
    assign w_mthi  = w_rtype && (funct_in == 6'h11);
    assign w_mflo  = w_rtype && (funct_in == 6'h12);
    assign w_mtlo  = w_rtype && (funct_in == 6'h13);

    assign w_is_mul    = w_mult | w_multu;
    assign w_is_div    = w_div | w_divu;
    assign w_is_signed = w_mult | w_div;
    assign w_hilo_use  = valid_in & (w_is_mul | w_is_div | w_mfhi | w_mthi | w_mflo | w_mtlo);

    assign w_busy   = (r_state != IDLE);
    assign stall    = w_busy & w_hilo_use;
    assign w_accept = w_hilo_use & ~stall;
    assign w_b_zero = (valB_in == '0);
    assign w_start  = w_accept & (w_is_mul | (w_is_div & ~w_b_zero));

    assign w_abs_a = (w_is_signed && valA_in[XLEN-1]) ? -valA_in : valA_in;
    assign w_abs_b = (w_is_signed && valB_in[XLEN-1]) ? -valB_in : valB_in;

    assign result_valid = w_hilo_use & (w_mfhi | w_mflo) & ~stall;
    assign result       = !result_valid ? '0 : (w_mfhi ? r_hi : r_lo);
    assign hi_out       = r_hi;
    assign lo_out       = r_lo;
    assign div_by_zero  = r_dbz;

    // Restoring divide: partial remainder shifted left with the next dividend bit.
    assign w_trial    = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
    assign w_diff     = w_trial - {1'b0, r_opa[XLEN-1:0]};
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;

`ifdef MULDIV_EARLY_TERM_EN
    assign w_mul_done = r_is_mul && (r_opb[XLEN-1:1] == '0);
`else
    assign w_mul_done = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if ((r_cnt == LP_LAST) || w_mul_done) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_mul <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_dbz <= w_accept & w_is_div & w_b_zero;
            // MTHI/MTLO can only be accepted in IDLE, so they never collide with FIX.
            if (w_accept & w_mthi) r_hi <= valA_in;
            if (w_accept & w_mtlo) r_lo <= valA_in;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_is_mul <= w_is_mul;
                        r_neg_q  <= w_is_signed & (valA_in[XLEN-1] ^ valB_in[XLEN-1]);
                        r_neg_r  <= w_is_signed & valA_in[XLEN-1];
                        r_opa    <= {{XLEN{1'b0}}, (w_is_mul ? w_abs_a : w_abs_b)};
                        r_opb    <= w_is_mul ? w_abs_b : w_abs_a;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_is_mul) begin
                        if (r_opb[0]) r_acc <= r_acc + r_opa;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end else begin
                        if (!w_diff[XLEN]) r_acc[XLEN-1:0] <= w_diff[XLEN-1:0];
                        else               r_acc[XLEN-1:0] <= w_trial[XLEN-1:0];
                        r_opb <= {r_opb[XLEN-2:0], ~w_diff[XLEN]};
                    end
                end
                FIX: begin
                    if (r_is_mul) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else begin
                        r_lo <= r_neg_q ? -r_opb : r_opb;
                        r_hi <= r_neg_r ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: scoreboard of expected HI/LO and busy length per mul/div.
// Honours MULDIV_EARLY_TERM_EN when computing expected multiply latency.
module tb_ex_muldiv_unit;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [5:0]  op_in, funct_in;
    logic [31:0] valA_in, valB_in;
    logic        stall, result_valid, div_by_zero;
    logic [31:0] result, hi_out, lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .op_in(op_in), .funct_in(funct_in),
        .valA_in(valA_in), .valB_in(valB_in), .stall(stall), .result(result),
        .result_valid(result_valid), .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        e.cycles = 33;
        e.hi     = '0;
        e.lo     = '0;
        case (f)
            F_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = p;
            end
            F_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                e.lo = a / b;
                e.hi = a % b;
            end
        endcase
`ifdef MULDIV_EARLY_TERM_EN
        if (f == F_MULT || f == F_MULTU) begin
            logic [31:0] m;
            m = (f == F_MULT && b[31]) ? -b : b;
            e.cycles = 2;
            for (int i = 0; i < 32; i++) if (m[i]) e.cycles = i + 2;
        end
`endif
        return e;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        valid_in = 1'b1;
        op_in    = op;
        funct_in = f;
        valA_in  = a;
        valB_in  = b;
        if (op == 6'h00 && (f == F_MULT || f == F_MULTU || ((f == F_DIV || f == F_DIVU) && b != 0)))
            sb.push_back(model(f, a, b));
    endtask

    task automatic idle_in();
        @(negedge clock);
        valid_in = 1'b0;
        op_in    = '0;
        funct_in = '0;
        valA_in  = '0;
        valB_in  = '0;
    endtask

    // Counts stalled cycles of the instruction currently presented; -1 if it never unstalls.
    task automatic wait_unstalled(output int cycles);
        cycles = 0;
        #1;
        while (stall && cycles < 200) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        if (stall) cycles = -1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        op_in    = '0;
        funct_in = F_MFHI;
        valA_in  = '0;
        valB_in  = '0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin n_errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_out, lo_out); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        @(negedge clock);
        reset = 1'b0;
        idle_in();
    endtask

    task automatic run_and_check(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit read_hi, input int idx);
        int   cyc;
        exp_t e;
        issue(6'h00, f, a, b);
        issue(6'h00, read_hi ? F_MFHI : F_MFLO, 32'h0, 32'h0);
        wait_unstalled(cyc);
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++; $display("FAIL arith_sb_empty[%0d]: got 0 entries expected 1", idx);
        end else begin
            e = sb.pop_front();
            n_checks++; if (cyc !== e.cycles) begin n_errors++; $display("FAIL arith_stall_cycles[%0d] f=%h a=%h b=%h: got %0d expected %0d", idx, f, a, b, cyc, e.cycles); end
            n_checks++; if (result_valid !== 1'b1) begin n_errors++; $display("FAIL arith_result_valid[%0d]: got %b expected 1", idx, result_valid); end
            n_checks++; if (result !== (read_hi ? e.hi : e.lo)) begin n_errors++; $display("FAIL arith_result[%0d] f=%h a=%h b=%h: got %h expected %h", idx, f, a, b, result, read_hi ? e.hi : e.lo); end
            n_checks++; if (hi_out !== e.hi || lo_out !== e.lo) begin n_errors++; $display("FAIL arith_hilo[%0d] f=%h a=%h b=%h: got %h/%h expected %h/%h", idx, f, a, b, hi_out, lo_out, e.hi, e.lo); end
        end
        idle_in();
    endtask

    task automatic test_directed();
        logic [5:0]  fs [5] = '{F_MULTU, F_MULT, F_DIV, F_DIV, F_DIVU};
        logic [31:0] as [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] bs [5] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'hFFFF_FFFF, 32'd7};
        for (int i = 0; i < 5; i++) run_and_check(fs[i], as[i], bs[i], (i % 2) == 0, i);
    endtask

    task automatic test_random();
        logic [5:0]  fs [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            f = fs[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            run_and_check(f, a, b, (i % 2) == 1, 100 + i);
        end
    endtask

    task automatic test_div_by_zero();
        issue(6'h00, F_MTHI, 32'h11, 32'h0);
        issue(6'h00, F_MTLO, 32'h22, 32'h0);
        issue(6'h00, F_DIVU, 32'd5, 32'h0);
        #1;
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL dbz_before_edge: got %b expected 0", div_by_zero); end
        issue(6'h00, F_MFHI, 32'h0, 32'h0);
        #1;
        n_checks++; if (div_by_zero !== 1'b1) begin n_errors++; $display("FAIL dbz_pulse: got %b expected 1", div_by_zero); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL dbz_no_busy: got stall %b expected 0", stall); end
        n_checks++; if (result_valid !== 1'b1 || result !== 32'h11) begin n_errors++; $display("FAIL dbz_hi_kept: got %b/%h expected 1/00000011", result_valid, result); end
        issue(6'h00, F_MFLO, 32'h0, 32'h0);
        #1;
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL dbz_pulse_width: got %b expected 0", div_by_zero); end
        n_checks++; if (stall !== 1'b0 || result !== 32'h22) begin n_errors++; $display("FAIL dbz_lo_kept: got stall %b result %h expected 0/00000022", stall, result); end
        idle_in();
    endtask

    task automatic test_independence();
        int   cyc;
        int   alu_stalls = 0;
        exp_t e;
        issue(6'h00, F_MULTU, 32'h1234_5678, 32'h8765_4321);
        for (int i = 0; i < 5; i++) begin
            issue(6'h08, F_MULT, 32'h1, 32'h2);
            #1;
            if (stall) alu_stalls++;
        end
        n_checks++; if (alu_stalls !== 0) begin n_errors++; $display("FAIL indep_alu_stall: got %0d stalled cycles expected 0", alu_stalls); end
        issue(6'h00, F_MFLO, 32'h0, 32'h0);
        wait_unstalled(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles - 5) begin n_errors++; $display("FAIL indep_mflo_stall: got %0d expected %0d", cyc, e.cycles - 5); end
        n_checks++; if (result_valid !== 1'b1 || result !== e.lo) begin n_errors++; $display("FAIL indep_mflo: got %b/%h expected 1/%h", result_valid, result, e.lo); end
        idle_in();
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        issue(6'h00, F_MULTU, 32'hCAFE_F00D, 32'h9000_0001);
        issue(6'h00, F_MULTU, 32'h0000_BEEF, 32'hF000_0005);
        wait_unstalled(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_errors++; $display("FAIL b2b_first_stall: got %0d expected %0d", cyc, e.cycles); end
        n_checks++; if (hi_out !== e.hi || lo_out !== e.lo) begin n_errors++; $display("FAIL b2b_first_hilo: got %h/%h expected %h/%h", hi_out, lo_out, e.hi, e.lo); end
        issue(6'h00, F_MFHI, 32'h0, 32'h0);
        wait_unstalled(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_errors++; $display("FAIL b2b_second_stall: got %0d expected %0d", cyc, e.cycles); end
        n_checks++; if (result !== e.hi || lo_out !== e.lo) begin n_errors++; $display("FAIL b2b_second_result: got %h/%h expected %h/%h", result, lo_out, e.hi, e.lo); end
        idle_in();
    endtask

    task automatic test_reset_mid();
        int   cyc;
        exp_t e;
        issue(6'h00, F_MULTU, 32'hDEAD_BEEF, 32'h8000_0003);
        issue(6'h00, F_MFHI, 32'h0, 32'h0);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL rstmid_stall_before: got %b expected 1", stall); end
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
        n_checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin n_errors++; $display("FAIL rstmid_hilo: got %h/%h expected 0/0", hi_out, lo_out); end
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        issue(6'h00, F_MULTU, 32'd3, 32'd4);
        issue(6'h00, F_MFLO, 32'h0, 32'h0);
        wait_unstalled(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_errors++; $display("FAIL rstmid_new_stall: got %0d expected %0d", cyc, e.cycles); end
        n_checks++; if (result !== e.lo || hi_out !== e.hi) begin n_errors++; $display("FAIL rstmid_new_result: got lo %h hi %h expected %h/%h", result, hi_out, e.lo, e.hi); end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_independence();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL sb_drained: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
